// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control sequencer: state encoding,
// instruction field positions and the ALU control payload.
package hack_pkg;

  localparam int unsigned PC_W    = 15;
  localparam int unsigned WORD_W  = 16;

  // Instruction field positions
  localparam int unsigned A_FLAG  = 15;
  localparam int unsigned ABIT    = 12;
  localparam int unsigned CMP_HI  = 11;
  localparam int unsigned CMP_LO  = 6;
  localparam int unsigned DEST_HI = 5;
  localparam int unsigned DEST_LO = 3;
  localparam int unsigned JMP_HI  = 2;
  localparam int unsigned JMP_LO  = 0;

  // Individual destination bits inside DEST
  localparam int unsigned DEST_A  = DEST_HI;
  localparam int unsigned DEST_D  = DEST_HI - 1;
  localparam int unsigned DEST_M  = DEST_LO;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM_RD = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Bit order matches IR[11:6]
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Hack jump predicate: evaluates j1..j3 against the latched ALU flags.
module hack_jump_cond (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch over a req/ack port, decode, optional
// M read, drive the external ALU, then commit A/D/M and the next PC.
module hack_cpu_ctrl #(
  parameter int unsigned PC_W = hack_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic [15:0]     dmem_wdata,
  input  logic            dmem_ack,
  input  logic [15:0]     dmem_rdata,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     a_reg,
  output logic [15:0]     d_reg
);

  import hack_pkg::*;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt, pc_inc, imem_addr_nxt, dmem_addr_nxt;
  logic [15:0]     a_nxt, d_nxt, ir, ir_nxt, res, res_nxt;
  logic [15:0]     dmem_wdata_nxt, alu_x_nxt, alu_y_nxt;
  logic            res_zr, res_ng, zr_nxt, ng_nxt, take;
  logic            imem_req_nxt, dmem_req_nxt, dmem_we_nxt;
  alu_ctrl_t       ctrl, ctrl_nxt;

  assign pc_inc = pc + PC_W'(1);

  assign alu_zx = ctrl.zx;
  assign alu_nx = ctrl.nx;
  assign alu_zy = ctrl.zy;
  assign alu_ny = ctrl.ny;
  assign alu_f  = ctrl.f;
  assign alu_no = ctrl.no;

  hack_jump_cond u_jump (
    .j    (ir[JMP_HI:JMP_LO]),
    .zr   (res_zr),
    .ng   (res_ng),
    .take (take)
  );

  // State and datapath registers; reset discards any partial instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      ir         <= '0;
      res        <= '0;
      res_zr     <= 1'b0;
      res_ng     <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      ctrl       <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      a_reg      <= a_nxt;
      d_reg      <= d_nxt;
      ir         <= ir_nxt;
      res        <= res_nxt;
      res_zr     <= zr_nxt;
      res_ng     <= ng_nxt;
      imem_req   <= imem_req_nxt;
      imem_addr  <= imem_addr_nxt;
      dmem_req   <= dmem_req_nxt;
      dmem_we    <= dmem_we_nxt;
      dmem_addr  <= dmem_addr_nxt;
      dmem_wdata <= dmem_wdata_nxt;
      alu_x      <= alu_x_nxt;
      alu_y      <= alu_y_nxt;
      ctrl       <= ctrl_nxt;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    a_nxt          = a_reg;
    d_nxt          = d_reg;
    ir_nxt         = ir;
    res_nxt        = res;
    zr_nxt         = res_zr;
    ng_nxt         = res_ng;
    imem_addr_nxt  = imem_addr;
    dmem_addr_nxt  = dmem_addr;
    dmem_wdata_nxt = dmem_wdata;
    alu_x_nxt      = alu_x;
    alu_y_nxt      = alu_y;
    ctrl_nxt       = ctrl;

    unique case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir[A_FLAG]) begin
          a_nxt     = {1'b0, ir[A_FLAG-1:0]};
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = ir[ABIT] ? S_MEM_RD : S_EXEC;
        end
      end
      S_MEM_RD: begin
        if (dmem_ack) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        res_nxt   = alu_out;
        zr_nxt    = alu_zr;
        ng_nxt    = alu_ng;
        state_nxt = S_WB;
        if (ir[DEST_M]) dmem_wdata_nxt = alu_out;
      end
      S_WB: begin
        // A is still the pre-instruction value here, so the jump target is old A
        if (!ir[DEST_M] || dmem_ack) begin
          if (ir[DEST_A]) a_nxt = res;
          if (ir[DEST_D]) d_nxt = res;
          pc_nxt    = take ? a_reg[PC_W-1:0] : pc_inc;
          state_nxt = S_FETCH;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase

    imem_req_nxt = (state_nxt == S_FETCH);
    dmem_we_nxt  = (state_nxt == S_WB) && ir[DEST_M];
    dmem_req_nxt = (state_nxt == S_MEM_RD) || dmem_we_nxt;

    if (imem_req_nxt) imem_addr_nxt = pc_nxt;
    if (dmem_req_nxt && !dmem_req) dmem_addr_nxt = a_reg[PC_W-1:0];

    // Operands are loaded on entry to EXEC so they are stable for that cycle
    if (state_nxt == S_EXEC) begin
      alu_x_nxt = d_reg;
      alu_y_nxt = (state == S_MEM_RD) ? dmem_rdata : a_reg;
      ctrl_nxt  = alu_ctrl_t'(ir[CMP_HI:CMP_LO]);
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: behavioural ALU and memories, an
// ISA-level model feeding scoreboard queues, plus directed reset checks.
module tb_hack_cpu_ctrl;

  localparam int unsigned PC_W = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [PC_W-1:0] dmem_addr;
  logic [15:0]     dmem_wdata, dmem_rdata;
  logic [15:0]     alu_x, alu_y, alu_out;
  logic            alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [PC_W-1:0] pc;
  logic [15:0]     a_reg, d_reg;

  hack_cpu_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
  );

  always #5 clk = ~clk;

  // Hack ALU: returns {zr, ng, out}
  function automatic logic [17:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return {(o == 16'h0000), o[15], o};
  endfunction

  assign {alu_zr, alu_ng, alu_out} =
    alu_fn(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  exp_t        res_q[$];
  wr_t         wr_q[$];
  logic [14:0] rd_q[$];

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  int          dlat_tab [0:31];

  logic [14:0] m_pc;
  logic [15:0] m_a, m_d;
  int          cyc, start_cyc, exec_cyc, dl_cur, iwait, dwait, n_instr;
  logic        prev_ireq, d_active, cap_we;
  logic [14:0] cap_addr;
  logic [15:0] cap_wd, exp_x, exp_y;
  logic [5:0]  exp_ctrl;

  // ISA-level reference: predicts the architectural result of one instruction
  task automatic model_step(input logic [15:0] w, input int iw);
    exp_t        e;
    wr_t         wr;
    logic [15:0] y, r;
    logic [17:0] fr;
    logic        jmp;
    int          cy;
    if (!w[15]) begin
      m_a      = {1'b0, w[14:0]};
      m_pc     = m_pc + 15'd1;
      cy       = 2 + iw;
      exec_cyc = -1;
    end else begin
      y        = w[12] ? dmem[m_a[14:0]] : m_a;
      fr       = alu_fn(m_d, y, w[11:6]);
      r        = fr[15:0];
      exp_ctrl = w[11:6];
      exp_x    = m_d;
      exp_y    = y;
      exec_cyc = cyc + 2 + (w[12] ? 1 + dl_cur : 0);
      cy       = 4 + iw + (w[12] ? 1 + dl_cur : 0) + (w[3] ? dl_cur : 0);
      if (w[12]) rd_q.push_back(m_a[14:0]);
      if (w[3]) begin
        wr.addr = m_a[14:0];
        wr.data = r;
        wr_q.push_back(wr);
      end
      jmp  = (w[2] & fr[16]) | (w[1] & fr[17]) | (w[0] & ~fr[16] & ~fr[17]);
      m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
      if (w[5]) m_a = r;
      if (w[4]) m_d = r;
    end
    e.pc  = m_pc;
    e.a   = m_a;
    e.d   = m_d;
    e.cyc = 16'(cy);
    res_q.push_back(e);
  endtask

  // Memory responders, model feed and scoreboard, all on the falling edge
  initial begin : bus
    exp_t e;
    wr_t  w;
    logic [14:0] ra;
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = 16'hFFFF;
    dmem_rdata = 16'hDEAD;
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
    for (int i = 0; i < 32; i++) dlat_tab[i] = 0;
    imem[0]  = 16'h0005;  imem[1]  = 16'h0007;  imem[2]  = 16'hEC10;
    imem[3]  = 16'hE7D0;  imem[4]  = 16'h0003;  imem[5]  = 16'hE308;
    imem[6]  = 16'h0010;  imem[7]  = 16'hEE90;  imem[8]  = 16'hE304;
    imem[16] = 16'hEA90;  imem[17] = 16'h0010;  imem[18] = 16'hE304;
    imem[19] = 16'h0004;  imem[20] = 16'hFDE8;  imem[21] = 16'h7FFF;
    imem[22] = 16'hEA87;  imem[32767] = 16'h0002;
    dmem[4]  = 16'h0009;
    dlat_tab[5]  = 3;
    dlat_tab[20] = 1;
    cyc = 0;
    n_instr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_ack   = 1'b0;
      dmem_ack   = 1'b0;
      imem_rdata = 16'hFFFF;
      dmem_rdata = 16'hDEAD;
      if (!rst_n) begin
        m_pc = '0; m_a = '0; m_d = '0;
        res_q.delete(); wr_q.delete(); rd_q.delete();
        prev_ireq = 1'b0; d_active = 1'b0;
        iwait = 0; dwait = 0; dl_cur = 0; exec_cyc = -1; start_cyc = cyc;
        continue;
      end
      check_eq("req_excl", 32'(imem_req & dmem_req), 32'd0);
      if (imem_req && !prev_ireq) begin
        if (res_q.size() > 0) begin
          e = res_q.pop_front();
          n_instr++;
          check_eq("commit_pc", 32'(pc), 32'(e.pc));
          check_eq("commit_a", 32'(a_reg), 32'(e.a));
          check_eq("commit_d", 32'(d_reg), 32'(e.d));
          check_eq("instr_cycles", 32'(cyc - start_cyc), 32'(e.cyc));
        end
        start_cyc = cyc;
      end
      prev_ireq = imem_req;
      if (cyc == exec_cyc) begin
        check_eq("alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'(exp_ctrl));
        check_eq("alu_x", 32'(alu_x), 32'(exp_x));
        check_eq("alu_y", 32'(alu_y), 32'(exp_y));
      end
      if (imem_req) begin
        check_eq("imem_addr", 32'(imem_addr), 32'(pc));
        if (iwait >= ((imem_addr == 15'd2) ? 2 : 0)) begin
          check_eq("fetch_pc", 32'(imem_addr), 32'(m_pc));
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr];
          dl_cur     = dlat_tab[imem_addr[4:0]];
          model_step(imem_rdata, iwait);
          iwait = 0;
        end else begin
          iwait++;
        end
      end
      if (dmem_req) begin
        if (!d_active) begin
          d_active = 1'b1;
          cap_we   = dmem_we;
          cap_addr = dmem_addr;
          cap_wd   = dmem_wdata;
        end else begin
          check_eq("dmem_hold", {dmem_we, dmem_addr, dmem_wdata}, {cap_we, cap_addr, cap_wd});
        end
        if (dwait >= dl_cur) begin
          dmem_ack = 1'b1;
          dwait    = 0;
          d_active = 1'b0;
          if (dmem_we) begin
            if (wr_q.size() == 0) begin
              check_eq("wr_unexpected", 32'(dmem_addr), 32'h7FFF_FFFF);
            end else begin
              w = wr_q.pop_front();
              check_eq("wr_addr", 32'(dmem_addr), 32'(w.addr));
              check_eq("wr_data", 32'(dmem_wdata), 32'(w.data));
            end
            dmem[dmem_addr] = dmem_wdata;
          end else begin
            if (rd_q.size() == 0) begin
              check_eq("rd_unexpected", 32'(dmem_addr), 32'h7FFF_FFFF);
            end else begin
              ra = rd_q.pop_front();
              check_eq("rd_addr", 32'(dmem_addr), 32'(ra));
            end
            dmem_rdata = dmem[dmem_addr];
          end
        end else begin
          dwait++;
        end
      end
    end
  end

  initial begin : main
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_a", 32'(a_reg), 32'd0);
    check_eq("rst_d", 32'(d_reg), 32'd0);
    check_eq("rst_reqs", 32'({imem_req, dmem_req, dmem_we}), 32'd0);
    check_eq("rst_alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
    check_eq("rst_alu_ops", {alu_x, alu_y}, 32'd0);

    rst_n = 1'b1;
    check_eq("idle_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_eq("first_fetch_req", 32'(imem_req), 32'd1);

    t = 0;
    while (n_instr < 17 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("run_complete", 32'(n_instr >= 17), 32'd1);

    // Second pass: stall the M=D write long enough to reset inside WB
    dlat_tab[5] = 50;
    t = 0;
    while (!(dmem_req && dmem_we) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("wb_wait_reached", 32'(dmem_req && dmem_we), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_dmem", 32'({dmem_req, dmem_we}), 32'd0);
    check_eq("midrst_imem", 32'(imem_req), 32'd0);
    check_eq("midrst_pc", 32'(pc), 32'd0);
    check_eq("midrst_ad", {a_reg, d_reg}, 32'd0);
    rst_n = 1'b1;
    check_eq("midrst_idle", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_eq("midrst_refetch", 32'(imem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
